// File: rtl/note_hit_judge.sv
// Judges player button presses against the lit lanes of each beat window and
// runs the IDLE/PLAY/OVER game, tracking score, combo and lives.
module note_hit_judge #(
    parameter int SCORE_W     = 16,
    parameter int LIVES       = 3,
    parameter int BEATS       = 11,
    parameter int COMBO_BONUS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               beat_tick,
    input  logic               line1,
    input  logic               line2,
    input  logic               line3,
    input  logic               btn1,
    input  logic               btn2,
    input  logic               btn3,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo,
    output logic [2:0]         lives,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               playing,
    output logic               game_over
);

    localparam int         BCNT_W     = $clog2(BEATS + 1);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t              state_q;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [7:0]          combo_q, combo_d;
    logic [2:0]          lives_q, lives_d;
    logic [BCNT_W-1:0]   beat_cnt_q;
    logic [2:0]          expected_q, pressed_q;
    logic                win_valid_q;
    logic                hit_pulse_q, miss_pulse_q, playing_q, game_over_q;

    // Buttons are asynchronous: two flops to resynchronise, a third for edge detect.
    logic [2:0] sync1_q, sync2_q, sync3_q;
    logic [2:0] press_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            sync3_q <= 3'b000;
        end else begin
            sync1_q <= {btn3, btn2, btn1};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign press_edge = sync2_q & ~sync3_q;

    logic [2:0]       hit_w, miss_w, wrong_w;
    logic             err_w;
    logic [1:0]       hit_cnt_w;
    logic [2:0]       gain_w;
    logic [SCORE_W:0] score_sum_w;

    assign hit_w       = expected_q & pressed_q;
    assign miss_w      = expected_q & ~pressed_q;
    assign wrong_w     = ~expected_q & pressed_q;
    assign err_w       = (|miss_w) | (|wrong_w);
    assign hit_cnt_w   = 2'(hit_w[0]) + 2'(hit_w[1]) + 2'(hit_w[2]);
    assign gain_w      = (combo_q >= 8'(COMBO_BONUS)) ? {hit_cnt_w, 1'b0} : {1'b0, hit_cnt_w};
    assign score_sum_w = {1'b0, score_q} + (SCORE_W + 1)'(gain_w);

    // Outcome of the window closing on this beat_tick.
    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        lives_d = lives_q;
        if (err_w) begin
            combo_d = 8'd0;
            if (lives_q != 3'd0) begin
                lives_d = lives_q - 3'd1;
            end
        end else if (|hit_w) begin
            score_d = score_sum_w[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_w[SCORE_W-1:0];
            combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            score_q      <= '0;
            combo_q      <= 8'd0;
            lives_q      <= LIVES_INIT;
            beat_cnt_q   <= '0;
            expected_q   <= 3'b000;
            pressed_q    <= 3'b000;
            win_valid_q  <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q     <= S_PLAY;
                        playing_q   <= 1'b1;
                        game_over_q <= 1'b0;
                        score_q     <= '0;
                        combo_q     <= 8'd0;
                        lives_q     <= LIVES_INIT;
                        beat_cnt_q  <= '0;
                        expected_q  <= 3'b000;
                        pressed_q   <= 3'b000;
                        win_valid_q <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (lives_q == 3'd0 || beat_cnt_q == BCNT_W'(BEATS)) begin
                        state_q     <= S_OVER;
                        playing_q   <= 1'b0;
                        game_over_q <= 1'b1;
                    end else if (beat_tick) begin
                        if (win_valid_q) begin
                            score_q      <= score_d;
                            combo_q      <= combo_d;
                            lives_q      <= lives_d;
                            hit_pulse_q  <= ~err_w & (|hit_w);
                            miss_pulse_q <= err_w;
                            beat_cnt_q   <= beat_cnt_q + BCNT_W'(1);
                        end
                        expected_q  <= {line3, line2, line1};
                        // A press landing on the tick belongs to the window now opening.
                        pressed_q   <= press_edge;
                        win_valid_q <= 1'b1;
                    end else begin
                        pressed_q <= pressed_q | press_edge;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    playing_q   <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign lives      = lives_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign playing    = playing_q;
    assign game_over  = game_over_q;

endmodule
